vs_interval_timer: RTL and testbench

VS_INTERVAL_TIMER -- requirements
Module: vs_interval_timer

---
 rtl/vs_interval_timer.sv | 90 +++++++++
 tb/tb_vs_interval_timer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vs_interval_timer.sv
// Interval timer: counts a latched period, pulses tick at each interval end,
// runs one-shot or auto-reload, and keeps a saturating count of ticks.
module vs_interval_timer #(
  parameter int unsigned N = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [N-1:0] period,
  output logic [N-1:0] count,
  output logic         tick,
  output logic         busy,
  output logic [N-1:0] ticks
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] TICKS_MAX = '1;

  state_t       state_q, state_d;
  logic [N-1:0] pl_q, pl_d;
  logic         mode_q, mode_d;
  logic [N-1:0] count_d, ticks_d;
  logic         tick_d, busy_d;
  logic         accept, terminal;

  assign accept   = start & ~stop & (period != '0);
  assign terminal = (count == pl_q - N'(1));

  // State and all outputs live in flops; reset clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pl_q    <= '0;
      mode_q  <= 1'b0;
      count   <= '0;
      ticks   <= '0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      mode_q  <= mode_d;
      count   <= count_d;
      ticks   <= ticks_d;
      tick    <= tick_d;
      busy    <= busy_d;
    end
  end

  // Priority: stop, then accepted start (restart), then normal counting.
  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    mode_d  = mode_q;
    count_d = count;
    ticks_d = ticks;
    tick_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (accept) begin
      state_d = RUN;
      pl_d    = period;
      mode_d  = periodic;
      count_d = '0;
      ticks_d = '0;
    end else if (state_q == RUN) begin
      if (terminal) begin
        tick_d  = 1'b1;
        count_d = '0;
        if (ticks != TICKS_MAX) ticks_d = ticks + N'(1);
        if (!mode_q) state_d = IDLE;
      end else begin
        count_d = count + N'(1);
      end
    end else begin
      count_d = '0;
    end

    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_vs_interval_timer.sv
// Scoreboard bench for vs_interval_timer (N=4): stimulus pushes expected
// outputs from a behavioural model; a negedge monitor pops and compares.
module tb_vs_interval_timer;

  localparam int unsigned N = 4;
  localparam int MAXT = (1 << N) - 1;

  logic         clock, reset_n, start, stop, periodic;
  logic [N-1:0] period, count, ticks;
  logic         tick, busy;

  vs_interval_timer #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .count(count), .tick(tick),
    .busy(busy), .ticks(ticks)
  );

  typedef struct {
    int count;
    int tick;
    int busy;
    int ticks;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;

  // Reference model state: position in interval, interval length, mode, tick total.
  bit m_run, m_oneshot;
  int m_pos, m_plen, m_nt, m_tick;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_oneshot = 0; m_pos = 0; m_plen = 0; m_nt = 0; m_tick = 0;
  endtask

  // One clock edge of the timer, stated as interval arithmetic.
  task automatic model_step(input bit s, input bit st, input int per, input bit pm);
    m_tick = 0;
    if (st) begin
      m_run = 0; m_pos = 0;
    end else if (s && per != 0) begin
      m_run = 1; m_plen = per; m_oneshot = !pm; m_pos = 0; m_nt = 0;
    end else if (m_run) begin
      if (m_pos + 1 >= m_plen) begin
        m_tick = 1; m_pos = 0;
        m_nt = (m_nt < MAXT) ? m_nt + 1 : MAXT;
        if (m_oneshot) m_run = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else begin
      m_pos = 0;
    end
  endtask

  // Called at negedge+1: apply inputs, optionally pulse reset between edges,
  // push the expected post-edge outputs, then advance to the next slot.
  task automatic drive(input bit s, input bit st, input int per, input bit pm, input bit rst);
    exp_t e;
    start = s; stop = st; period = N'(per); periodic = pm;
    if (rst) begin
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_tick", int'(tick), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_ticks", int'(ticks), 0);
      reset_n = 1'b1;
      model_reset();
    end
    model_step(s, st, per, pm);
    e.count = m_pos; e.tick = m_tick; e.busy = int'(m_run); e.ticks = m_nt;
    exp_q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, int'($urandom_range(0, MAXT)), 1'($urandom), 0);
  endtask

  // Monitor: every negedge compares the outputs of the edge just taken.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", int'(count), e.count);
      chk("tick", int'(tick), e.tick);
      chk("busy", int'(busy), e.busy);
      chk("ticks", int'(ticks), e.ticks);
    end
  end

  initial begin
    reset_n = 1'b0; start = 0; stop = 0; periodic = 0; period = '0;
    model_reset();
    #3;
    chk("reset_count", int'(count), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ticks", int'(ticks), 0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Periodic P=4 starting on the first edge after reset release.
    drive(1, 0, 4, 1, 0);
    idle(13);
    // One-shot P=3.
    drive(1, 0, 3, 0, 0);
    idle(6);
    // Periodic P=5, stop when count reaches 4.
    drive(1, 0, 5, 1, 0);
    idle(9);
    drive(0, 1, 5, 1, 0);
    idle(3);
    // period=0 is ignored; then P=1 ticks every cycle.
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0);
    idle(20);
    // Restart on the terminal cycle suppresses that tick.
    drive(1, 0, 3, 1, 0);
    idle(2);
    drive(1, 0, 6, 1, 0);
    idle(4);
    // Reset pulsed between edges mid-run.
    drive(1, 0, 7, 1, 0);
    idle(3);
    drive(0, 0, 7, 1, 1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit s, st, rst;
      s   = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      drive(s, st, int'($urandom_range(0, MAXT)), 1'($urandom), rst);
    end

    @(negedge clock);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
